// File: rtl/fat_pkg.sv
// Shared FAT directory-entry definitions.
// Holds the entry field constants, the entry-writer state type and the
// mapping from an LFN entry byte offset to its UCS-2 character slot. The
// directory parser uses the same mapping to gather name characters.
package fat_pkg;

  localparam logic [7:0] ATTR_LFN     = 8'h0F;
  localparam logic [7:0] ATTR_ARCHIVE = 8'h20;
  localparam logic [7:0] LFN_LAST     = 8'h40;
  localparam int         LFN_CHARS    = 13;
  localparam int         ENTRY_BYTES  = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CKSUM,
    ST_LFN,
    ST_SFN,
    ST_FIN
  } state_t;

  // is_char: offset lies inside a character slot
  // hi     : offset is the upper byte of the little-endian slot
  // k      : slot number 0..12
  typedef struct packed {
    logic       is_char;
    logic       hi;
    logic [3:0] k;
  } lfn_slot_t;

  // Slots occupy 0x01-0x0A (k 0..4), 0x0E-0x19 (k 5..10), 0x1C-0x1F (k 11..12).
  function automatic lfn_slot_t lfn_slot(input logic [4:0] off);
    lfn_slot_t s;
    s = '0;
    if (off >= 5'h01 && off <= 5'h0A) begin
      s.is_char = 1'b1;
      s.k       = 4'((off - 5'h01) >> 1);
      s.hi      = ~off[0];
    end else if (off >= 5'h0E && off <= 5'h19) begin
      s.is_char = 1'b1;
      s.k       = 4'd5 + 4'((off - 5'h0E) >> 1);
      s.hi      = off[0];
    end else if (off >= 5'h1C) begin
      s.is_char = 1'b1;
      s.k       = 4'd11 + 4'((off - 5'h1C) >> 1);
      s.hi      = off[0];
    end
    return s;
  endfunction

endpackage

// File: rtl/lfn_checksum.sv
// Sequential short-name checksum for LFN entries.
// Consumes one 8.3 name byte per i_valid cycle, rotate-right-then-add,
// over exactly 11 bytes.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_start   : clears the running sum and byte count
//   i_byte    : name byte consumed when i_valid=1
//   i_valid   : byte strobe
//   o_sum     : running sum; final and held once 11 bytes are consumed
//   o_done    : high in the cycle the 11th byte is being consumed
module lfn_checksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  input  logic       i_valid,
  output logic [7:0] o_sum,
  output logic       o_done
);

  logic [7:0] r_sum;
  logic [3:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= 8'h00;
      r_cnt <= 4'd0;
    end else if (i_start) begin
      r_sum <= 8'h00;
      r_cnt <= 4'd0;
    end else if (i_valid && r_cnt != 4'd11) begin
      r_sum <= {r_sum[0], r_sum[7:1]} + i_byte;
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Combinational so the writer can leave CKSUM in the same cycle; the sum
  // itself settles one clock later, well before byte 0x0D is generated.
  assign o_done = i_valid && (r_cnt == 4'd10);
  assign o_sum  = r_sum;

endmodule

// File: rtl/dir_entry_writer.sv
// FAT directory entry writer.
// Emits an optional LFN chain (N = ceil(len/13) entries, highest ordinal
// first) followed by one 8.3 short entry, 32 bytes per entry, as a byte
// stream addressed by entry index and byte offset.
// Handshake: a byte moves when wvalid and wready are both 1 on a rising
// clock edge; wvalid never depends on wready, and waddr/wentry/wdata/wlast
// hold while wvalid=1 and wready=0.
// Ports:
//   clk, rst_n       : clock, asynchronous active-high reset
//   start            : request pulse, accepted only while busy=0
//   lfn_en           : 1 = LFN chain + short entry, 0 = short entry only
//   fnamelen, fname  : long name length and characters (index 0 first)
//   sname            : 11-byte space-padded 8.3 name
//   fcluster, fsize  : first cluster and file size
//   busy             : request in progress
//   wvalid/wready    : byte handshake
//   waddr, wentry    : byte offset within entry, entry index in request
//   wdata, wlast     : byte value, last byte of the short entry
//   done, err        : completion pulse, err=1 means request rejected
//   dbg_state        : current FSM state
module dir_entry_writer
  import fat_pkg::*;
#(
  parameter int MAX_NAME = 52
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     lfn_en,
  input  logic [7:0]               fnamelen,
  input  logic [MAX_NAME-1:0][7:0] fname,
  input  logic [10:0][7:0]         sname,
  input  logic [15:0]              fcluster,
  input  logic [31:0]              fsize,
  output logic                     busy,
  output logic                     wvalid,
  input  logic                     wready,
  output logic [4:0]               waddr,
  output logic [2:0]               wentry,
  output logic [7:0]               wdata,
  output logic                     wlast,
  output logic                     done,
  output logic                     err,
  output state_t                   dbg_state
);

  localparam logic [4:0] LAST_OFF = 5'(ENTRY_BYTES - 1);

  state_t                   r_state;
  logic                     r_busy;
  logic                     r_wvalid;
  logic [4:0]               r_waddr;
  logic [2:0]               r_wentry;
  logic [7:0]               r_wdata;
  logic                     r_wlast;
  logic                     r_done;
  logic                     r_err;
  logic [2:0]               r_seq;
  logic [2:0]               r_n;
  logic [3:0]               r_cidx;
  logic [7:0]               r_len;
  logic [MAX_NAME-1:0][7:0] r_fname;
  logic [10:0][7:0]         r_sname;
  logic [15:0]              r_fcluster;
  logic [31:0]              r_fsize;

  logic       w_xfer;
  logic [2:0] w_n;
  logic       w_bad_len;
  logic       w_cks_start;
  logic       w_cks_valid;
  logic [7:0] w_cks_byte;
  logic [7:0] w_cks_sum;
  logic       w_cks_done;
  logic [4:0] w_nx_addr;
  logic [2:0] w_nx_seq;
  logic       w_nx_lfn;
  lfn_slot_t  w_slot;
  logic [5:0] w_idx;
  logic [7:0] w_fname_ch;
  logic [7:0] w_nx_byte;

  assign w_xfer    = r_wvalid && wready;
  assign w_bad_len = (fnamelen == 8'd0) || (fnamelen > 8'(MAX_NAME));

  always_comb begin
    w_n = 3'd4;
    if (fnamelen <= 8'd13)      w_n = 3'd1;
    else if (fnamelen <= 8'd26) w_n = 3'd2;
    else if (fnamelen <= 8'd39) w_n = 3'd3;
  end

  assign w_cks_start = (r_state == ST_IDLE) && start && lfn_en;
  assign w_cks_valid = (r_state == ST_CKSUM);
  assign w_cks_byte  = r_sname[r_cidx];

  lfn_checksum u_cksum (
    .clk     (clk),
    .rst     (rst_n),
    .i_start (w_cks_start),
    .i_byte  (w_cks_byte),
    .i_valid (w_cks_valid),
    .o_sum   (w_cks_sum),
    .o_done  (w_cks_done)
  );

  // Position of the byte that follows the current one in the stream.
  always_comb begin
    w_nx_addr = r_waddr + 5'd1;
    w_nx_seq  = r_seq;
    w_nx_lfn  = (r_state == ST_LFN);
    if (r_state == ST_LFN && r_waddr == LAST_OFF) begin
      w_nx_seq = r_seq - 3'd1;
      w_nx_lfn = (r_seq != 3'd1);
    end
  end

  // Value of that next byte; registered into wdata on the transfer.
  always_comb begin
    w_slot     = lfn_slot(w_nx_addr);
    w_idx      = 6'(w_nx_seq - 3'd1) * 6'(LFN_CHARS) + {2'b00, w_slot.k};
    w_fname_ch = (w_idx < 6'(MAX_NAME)) ? r_fname[w_idx] : 8'h00;
    w_nx_byte  = 8'h00;
    if (w_nx_lfn) begin
      if (w_nx_addr == 5'h00)
        w_nx_byte = {5'b0, w_nx_seq} | ((w_nx_seq == r_n) ? LFN_LAST : 8'h00);
      else if (w_nx_addr == 5'h0B)
        w_nx_byte = ATTR_LFN;
      else if (w_nx_addr == 5'h0D)
        w_nx_byte = w_cks_sum;
      else if (w_slot.is_char) begin
        // Name chars, then one 0x0000 terminator, then 0xFFFF padding.
        if ({2'b00, w_idx} < r_len)
          w_nx_byte = w_slot.hi ? 8'h00 : w_fname_ch;
        else if ({2'b00, w_idx} == r_len)
          w_nx_byte = 8'h00;
        else
          w_nx_byte = 8'hFF;
      end
    end else begin
      if (w_nx_addr <= 5'h0A)
        w_nx_byte = r_sname[w_nx_addr[3:0]];
      else if (w_nx_addr == 5'h0B)
        w_nx_byte = ATTR_ARCHIVE;
      else if (w_nx_addr == 5'h1A)
        w_nx_byte = r_fcluster[7:0];
      else if (w_nx_addr == 5'h1B)
        w_nx_byte = r_fcluster[15:8];
      else if (w_nx_addr >= 5'h1C) begin
        case (w_nx_addr[1:0])
          2'd0:    w_nx_byte = r_fsize[7:0];
          2'd1:    w_nx_byte = r_fsize[15:8];
          2'd2:    w_nx_byte = r_fsize[23:16];
          default: w_nx_byte = r_fsize[31:24];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_wvalid   <= 1'b0;
      r_waddr    <= 5'd0;
      r_wentry   <= 3'd0;
      r_wdata    <= 8'h00;
      r_wlast    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_seq      <= 3'd0;
      r_n        <= 3'd0;
      r_cidx     <= 4'd0;
      r_len      <= 8'd0;
      r_fname    <= '0;
      r_sname    <= '0;
      r_fcluster <= 16'h0000;
      r_fsize    <= 32'h0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy     <= 1'b1;
            r_len      <= fnamelen;
            r_fname    <= fname;
            r_sname    <= sname;
            r_fcluster <= fcluster;
            r_fsize    <= fsize;
            r_n        <= w_n;
            r_cidx     <= 4'd0;
            r_waddr    <= 5'd0;
            r_wentry   <= 3'd0;
            r_wlast    <= 1'b0;
            if (lfn_en && w_bad_len) begin
              r_state <= ST_FIN;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (lfn_en) begin
              r_state <= ST_CKSUM;
            end else begin
              r_state  <= ST_SFN;
              r_wvalid <= 1'b1;
              r_wdata  <= sname[0];
            end
          end
        end
        ST_CKSUM: begin
          r_cidx <= r_cidx + 4'd1;
          if (w_cks_done) begin
            r_state  <= ST_LFN;
            r_cidx   <= 4'd0;
            r_seq    <= r_n;
            r_wvalid <= 1'b1;
            r_wdata  <= LFN_LAST | {5'b0, r_n};
          end
        end
        ST_LFN: begin
          if (w_xfer) begin
            r_waddr <= w_nx_addr;
            r_seq   <= w_nx_seq;
            r_wdata <= w_nx_byte;
            if (r_waddr == LAST_OFF)
              r_wentry <= r_wentry + 3'd1;
            if (!w_nx_lfn)
              r_state <= ST_SFN;
          end
        end
        ST_SFN: begin
          if (w_xfer) begin
            r_waddr <= w_nx_addr;
            if (r_waddr == LAST_OFF) begin
              r_state  <= ST_FIN;
              r_wentry <= r_wentry + 3'd1;
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_wdata  <= 8'h00;
              r_done   <= 1'b1;
            end else begin
              r_wdata <= w_nx_byte;
              r_wlast <= (w_nx_addr == LAST_OFF);
            end
          end
        end
        ST_FIN: begin
          // done is high this cycle; busy falls as IDLE is entered.
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign wvalid    = r_wvalid;
  assign waddr     = r_waddr;
  assign wentry    = r_wentry;
  assign wdata     = r_wdata;
  assign wlast     = r_wlast;
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dir_entry_writer.sv
module tb_dir_entry_writer;
  import fat_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              start;
  logic              lfn_en;
  logic [7:0]        fnamelen;
  logic [51:0][7:0]  fname;
  logic [10:0][7:0]  sname;
  logic [15:0]       fcluster;
  logic [31:0]       fsize;
  logic              busy;
  logic              wvalid;
  logic              wready;
  logic [4:0]        waddr;
  logic [2:0]        wentry;
  logic [7:0]        wdata;
  logic              wlast;
  logic              done;
  logic              err;
  state_t            dbg_state;

  dir_entry_writer #(.MAX_NAME(52)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .lfn_en    (lfn_en),
    .fnamelen  (fnamelen),
    .fname     (fname),
    .sname     (sname),
    .fcluster  (fcluster),
    .fsize     (fsize),
    .busy      (busy),
    .wvalid    (wvalid),
    .wready    (wready),
    .waddr     (waddr),
    .wentry    (wentry),
    .wdata     (wdata),
    .wlast     (wlast),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [16:0] exp_q[$];   // {wlast, wentry, waddr, wdata}
  logic [7:0]  rx[$];
  logic [7:0]  rx_ref[$];

  logic [51:0][7:0] t_fname;
  logic [10:0][7:0] t_sname;
  logic [15:0]      t_clus;
  logic [31:0]      t_size;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_fname(input string s);
    t_fname = '0;
    for (int i = 0; i < s.len() && i < 52; i++) t_fname[i] = s[i];
  endtask

  task automatic set_sname(input string s);
    t_sname = {11{8'h20}};
    for (int i = 0; i < s.len() && i < 11; i++) t_sname[i] = s[i];
  endtask

  task automatic rand_fname(input int len);
    t_fname = '0;
    for (int i = 0; i < len; i++) t_fname[i] = 8'($urandom_range(33, 126));
  endtask

  function automatic logic [7:0] ref_cksum(input logic [10:0][7:0] s);
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < 11; i++) sum = {sum[0], sum[7:1]} + s[i];
    return sum;
  endfunction

  // Reference stream: LFN entries (ordinal N down to 1), then the short entry.
  task automatic build_exp(input bit lfn, input int len);
    int n;
    int offs[13] = '{1, 3, 5, 7, 9, 14, 16, 18, 20, 22, 24, 28, 30};
    logic [7:0] ck;
    logic [7:0] b;
    int seq, idx;
    n  = lfn ? (len + 12) / 13 : 0;
    ck = ref_cksum(t_sname);
    for (int e = 0; e < n; e++) begin
      seq = n - e;
      for (int a = 0; a < 32; a++) begin
        b = 8'h00;
        if (a == 0)       b = 8'(seq) | ((e == 0) ? 8'h40 : 8'h00);
        else if (a == 11) b = 8'h0F;
        else if (a == 13) b = ck;
        else begin
          for (int k = 0; k < 13; k++) begin
            if (a == offs[k] || a == offs[k] + 1) begin
              idx = (seq - 1) * 13 + k;
              if (idx < len)       b = (a == offs[k]) ? t_fname[idx] : 8'h00;
              else if (idx == len) b = 8'h00;
              else                 b = 8'hFF;
            end
          end
        end
        exp_q.push_back({1'b0, 3'(e), 5'(a), b});
      end
    end
    for (int a = 0; a < 32; a++) begin
      b = 8'h00;
      if (a < 11)       b = t_sname[a];
      else if (a == 11) b = 8'h20;
      else if (a == 26) b = t_clus[7:0];
      else if (a == 27) b = t_clus[15:8];
      else if (a >= 28) b = t_size[8*(a-28) +: 8];
      exp_q.push_back({(a == 31), 3'(n), 5'(a), b});
    end
  endtask

  // ---------------- driver + monitor ----------------
  // mode 0: wready always 1; mode 1: random wready.
  // poke_cyc: cycle at which a second start (with an illegal length) is
  // pulsed; rst_at: byte count at which reset is asserted (-1 = never).
  task automatic run_req(input bit lfn, input int len, input int mode,
                         input int poke_cyc, input int rst_at, input string tag);
    bit bad;
    int n, first_v, done_cyc, nbytes;
    logic err_seen, stalled, aborted;
    logic [16:0] hold, obs, e;
    bad      = lfn && (len == 0 || len > 52);
    n        = (lfn && !bad) ? (len + 12) / 13 : 0;
    first_v  = -1;
    done_cyc = -1;
    nbytes   = 0;
    err_seen = 1'b0;
    stalled  = 1'b0;
    aborted  = 1'b0;
    hold     = '0;
    rx.delete();
    exp_q.delete();
    if (!bad) build_exp(lfn, len);

    @(negedge clk);
    lfn_en   = lfn;
    fnamelen = 8'(len);
    fname    = t_fname;
    sname    = t_sname;
    fcluster = t_clus;
    fsize    = t_size;
    start    = 1'b1;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == poke_cyc) begin
        start    = 1'b1;
        lfn_en   = 1'b1;
        fnamelen = 8'd0;
        sname    = '0;
      end else if (c == poke_cyc + 1) begin
        lfn_en   = lfn;
        fnamelen = 8'(len);
        sname    = t_sname;
      end
      if (rst_at >= 0 && nbytes == rst_at) begin
        rst_n   = 1'b1;
        aborted = 1'b1;
        break;
      end
      wready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      obs = {wlast, wentry, waddr, wdata};
      if (wvalid && first_v < 0) first_v = c;
      if (stalled) check({tag, " stall_hold"}, obs, hold);
      if (done) begin
        done_cyc = c;
        err_seen = err;
        check({tag, " busy_at_done"}, busy, 1'b1);
        break;
      end
      if (wvalid && wready) begin
        if (exp_q.size() == 0) check({tag, " extra_byte"}, obs, 17'h1FFFF);
        else begin
          e = exp_q.pop_front();
          check({tag, " byte"}, obs, e);
        end
        rx.push_back(wdata);
        nbytes++;
        stalled = 1'b0;
      end else if (wvalid) begin
        stalled = 1'b1;
        hold    = obs;
      end else stalled = 1'b0;
    end

    if (!aborted) begin
      if (bad) begin
        check({tag, " no_wvalid"}, first_v, -1);
        check({tag, " done_cycle"}, done_cyc, 1);
        check({tag, " err"}, err_seen, 1'b1);
      end else begin
        check({tag, " first_wvalid"}, first_v, lfn ? 12 : 1);
        check({tag, " done_seen"}, (done_cyc >= 0), 1'b1);
        if (mode == 0) check({tag, " done_cycle"}, done_cyc, (lfn ? 12 : 1) + 32 * (n + 1));
        check({tag, " err"}, err_seen, 1'b0);
        check({tag, " queue_empty"}, exp_q.size(), 0);
      end
      @(negedge clk);
      check({tag, " busy_after"}, busy, 1'b0);
      check({tag, " done_after"}, done, 1'b0);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " busy"},   busy,   1'b0);
    check({tag, " wvalid"}, wvalid, 1'b0);
    check({tag, " done"},   done,   1'b0);
    check({tag, " err"},    err,    1'b0);
    check({tag, " wlast"},  wlast,  1'b0);
    check({tag, " waddr"},  waddr,  5'd0);
    check({tag, " wentry"}, wentry, 3'd0);
    check({tag, " wdata"},  wdata,  8'h00);
    check({tag, " state"},  dbg_state, ST_IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int nff;
    rst_n    = 1'b1;
    start    = 1'b0;
    lfn_en   = 1'b0;
    fnamelen = 8'd0;
    fname    = '0;
    sname    = '0;
    fcluster = 16'h0;
    fsize    = 32'h0;
    wready   = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b0;
    @(negedge clk);

    // short entry only
    set_fname("");
    set_sname("README  TXT");
    t_clus = 16'h1234;
    t_size = 32'h0001_0203;
    run_req(1'b0, 0, 0, -1, -1, "short");
    check("short len", rx.size(), 32);
    if (rx.size() == 32) begin
      check("short attr", rx[11], 8'h20);
      check("short clus_lo", rx[26], 8'h34);
      check("short clus_hi", rx[27], 8'h12);
      check("short size0", rx[28], 8'h03);
      check("short size1", rx[29], 8'h02);
      check("short size2", rx[30], 8'h01);
      check("short size3", rx[31], 8'h00);
    end

    // one LFN entry
    set_fname("hello.c");
    set_sname("HELLO   C  ");
    t_clus = 16'h0042;
    t_size = 32'h0000_1000;
    run_req(1'b1, 7, 0, -1, -1, "lfn1");
    check("lfn1 len", rx.size(), 64);
    if (rx.size() == 64) begin
      check("lfn1 ord", rx[0], 8'h41);
      check("lfn1 cksum", rx[13], ref_cksum(t_sname));
      check("lfn1 term_lo", rx[18], 8'h00);
      check("lfn1 term_hi", rx[19], 8'h00);
      check("lfn1 pad8", {rx[21], rx[20]}, 16'hFFFF);
      check("lfn1 pad12", {rx[31], rx[30]}, 16'hFFFF);
      check("lfn1 short_attr", rx[43], 8'h20);
    end

    // exact multiple of 13, with a start pulsed while busy
    set_fname("abcdefghijklmnopqrstuvwxyz");
    set_sname("ABCDEF~1TXT");
    run_req(1'b1, 26, 0, 30, -1, "lfn26");
    check("lfn26 len", rx.size(), 96);
    nff = 0;
    for (int i = 0; i < rx.size() && i < 64; i++) if (rx[i] == 8'hFF) nff++;
    check("lfn26 no_ffff", nff, 0);
    if (rx.size() == 96) check("lfn26 ord", rx[0], 8'h42);

    // maximum length
    rand_fname(52);
    set_sname("LONGNA~1DAT");
    t_size = 32'hDEAD_BEEF;
    run_req(1'b1, 52, 0, -1, -1, "lfn52");
    check("lfn52 len", rx.size(), 160);
    if (rx.size() == 160) begin
      check("lfn52 ord", rx[0], 8'h44);
      check("lfn52 ord2", rx[32], 8'h03);
    end

    // rejected lengths
    run_req(1'b1, 53, 0, -1, -1, "len53");
    run_req(1'b1, 0, 0, -1, -1, "len0");

    // backpressure: same bytes as the free-running run
    rand_fname(20);
    set_sname("BACKPR~1BIN");
    t_clus = 16'hA5C3;
    t_size = 32'h0000_0014;
    run_req(1'b1, 20, 0, -1, -1, "bp_ref");
    rx_ref = rx;
    run_req(1'b1, 20, 1, -1, -1, "bp_rand");
    check("bp len", rx.size(), rx_ref.size());
    for (int i = 0; i < rx.size() && i < rx_ref.size(); i++)
      check("bp byte", rx[i], rx_ref[i]);

    // reset in the middle of a request
    set_fname("hello.c");
    set_sname("HELLO   C  ");
    run_req(1'b1, 7, 0, -1, 40, "abort");
    #1;
    check_zero_outputs("abort");
    repeat (2) begin
      @(negedge clk);
      check("abort no_done", done, 1'b0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    set_sname("AFTER   RST");
    t_clus = 16'h0007;
    t_size = 32'h0000_0100;
    run_req(1'b0, 0, 0, -1, -1, "post_rst");
    check("post_rst len", rx.size(), 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dir_entry_writer.md
# dir_entry_writer

Generates FAT directory entries as a byte stream, the write-side counterpart of the directory parser. Given a file name, an 8.3 short name, a first cluster and a size, it emits an optional chain of long-file-name (LFN) entries followed by one short entry, 32 bytes per entry, through a valid/ready byte interface. It sits between the file-creation control logic and the sector buffer writer, which stores each byte at entry offset `waddr`.

## Interface
- `MAX_NAME`, default 52: maximum long-name length in characters, at most 4 LFN entries.
- `clk`  in  1: clock.
- `rst_n`  in  1: reset. One clock; reset is asynchronous and active-high.
- `start`  in  1: request pulse. Accepted only while `busy`=0.
- `lfn_en`  in  1: 1 emits the LFN chain plus the short entry; 0 emits the short entry only.
- `fnamelen`  in  8: long-name length. Valid range is 1..52.
- `fname`  in  8×52: long-name characters, ASCII, index 0 first.
- `sname`  in  8×11: 8.3 short name, space-padded, no dot.
- `fcluster`  in  16: first cluster.
- `fsize`  in  32: file size in bytes.
- `busy`  out  1: high from an accepted `start` until the cycle after `done`.
- `wvalid`  out  1: the byte on `wdata` is valid.
- `wready`  in  1: sink accepts the byte. A transfer happens when `wvalid` and `wready` are both 1.
- `waddr`  out  5: byte offset within the current entry.
- `wentry`  out  3: entry index within this request, 0-based.
- `wdata`  out  8: byte value.
- `wlast`  out  1: marks byte 31 of the short entry.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: qualifies `done`. 1 means the request was rejected.

## Operation
- States: IDLE, CKSUM, LFN, SFN, FIN.
- **IDLE.** On `start`, latch every input and set `busy`.
  - If `lfn_en`=1 and `fnamelen` is 0 or greater than 52: go to FIN with `err`=1.
  - Else if `lfn_en`=1: go to CKSUM.
  - Else: go to SFN.
- **CKSUM.** Takes 11 cycles, one `sname` byte per cycle.
  - Update: sum = {sum[0], sum[7:1]} + sname[i], mod 256, starting from sum=0.
  - N = ceil(fnamelen/13), so 1..4. Then go to LFN.
- **LFN.** Emits N entries with sequence numbers seq = N down to 1.
  - Offset 0x00: seq, with 0x40 OR'd in on the first emitted entry (seq=N).
  - Offset 0x0B: 0x0F. Offset 0x0C: 0x00. Offset 0x0D: checksum. Offsets 0x1A–0x1B: 0x00.
  - Character slots k=0..12 sit at offsets 0x01–0x0A, 0x0E–0x19 and 0x1C–0x1F. Each slot is 2 bytes, little-endian.
  - Slot k carries name index idx = (seq−1)·13 + k:
    - idx < len: {0x00, fname[idx]}.
    - idx = len: 0x0000.
    - idx > len: 0xFFFF.
  - After the last entry, go to SFN.
- **SFN.** Emits the short entry.
  - Offsets 0x00–0x0A: sname.
  - Offset 0x0B: 0x20.
  - Offsets 0x0C–0x19: 0x00.
  - Offsets 0x1A–0x1B: fcluster, little-endian.
  - Offsets 0x1C–0x1F: fsize, little-endian.
  - After byte 31 transfers, go to FIN.
- **FIN.** Pulse `done` for 1 cycle, then go to IDLE. `busy` drops in the IDLE cycle that follows.
- **Byte stepping.** `waddr` advances only on a transfer and wraps 31→0 with `wentry`+1.
- **Stall.** While `wvalid`=1 and `wready`=0, `waddr`, `wdata`, `wentry` and `wlast` hold stable.
- **Rejected start.** A `start` while `busy`=1 is ignored and has no side effect.
- **Upper-case input.** Characters are emitted verbatim, with no case folding. The parser upper-cases when it reads.

## Timing
- Reset values: `busy`, `wvalid`, `done`, `err`, `wlast` = 0. `waddr`, `wentry`, `wdata` = 0. State is IDLE.
- Reset mid-request: everything returns to reset values immediately, no `done` is produced, and the partial stream is abandoned.
- `start` sampled in cycle 0:
  - Short-only: first `wvalid` in cycle 1.
  - LFN: first `wvalid` in cycle 12 (11 CKSUM cycles).
  - Error: `done`/`err` in cycle 1, no bytes.
- With `wready` held at 1, one byte transfers per cycle.
  - `done` comes 1 cycle after the last transfer.
  - Total stream length is 32·(N+1) bytes, or 32 bytes for short-only.
- `wdata` is registered. There is no combinational path from `wready` to `wvalid`.

## Structure
- Shared package `fat_pkg` holds:
  - ATTR_LFN = 8'h0F, ATTR_ARCHIVE = 8'h20, LFN_LAST = 8'h40;
  - LFN_CHARS = 13, ENTRY_BYTES = 32;
  - the state enum type;
  - the slot-offset-to-k mapping function, also usable by the parser.
- Sub-module `lfn_checksum`: sequential 11-byte checksum with ports start/byte/valid/sum/done. It is instantiated once.

## Test plan
- **Short-only.** lfn_en=0, sname="README  TXT", fcluster=0x1234, fsize=0x00010203, wready=1.
  - Expect 32 bytes: byte 0x0B = 0x20; bytes 0x1A/0x1B = 0x34/0x12; bytes 0x1C..0x1F = 03,02,01,00.
  - Expect `wlast` on byte 31 and `done` with `err`=0 in cycle 33.
- **One LFN entry.** lfn_en=1, fname="hello.c" (len 7), sname="HELLO   C  ".
  - Expect 64 bytes.
  - Entry 0: byte 0 = 0x41; byte 0x0D = software-reference checksum; char 7 = 0x0000; chars 8..12 = 0xFFFF.
  - Entry 1 is the short entry.
- **Exact multiple.** len=26.
  - Expect N=2 and first ordinal 0x42.
  - No 0x0000 terminator appears, and no 0xFFFF appears.
- **Maximum and error cases.**
  - len=52: N=4, 160 bytes.
  - len=53: `done`&`err` in cycle 1, `wvalid` never asserted.
  - len=0: same as len=53.
- **Backpressure.** Toggle `wready` randomly over an entire len-20 request.
  - The byte sequence must equal the `wready`=1 run.
  - Outputs hold stable during stalls.
- **Interference.**
  - Assert `start` while busy: no effect.
  - Assert `rst_n` at byte 40: all outputs return to 0 next edge, no `done`, and a new request then completes normally.
